// File: rtl/spi_peri_pkg.sv
// rtl/spi_peri_pkg.sv - shared bit-order type, counter sizing and shift/parity helpers for the SPI peripheral
package spi_peri_pkg;

    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } bit_order_e;

    localparam int HELPER_MAX_W = 64;

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic logic even_parity(input logic [HELPER_MAX_W-1:0] word);
        return ^word;
    endfunction

    // Words are zero-extended to HELPER_MAX_W; the caller truncates back to w bits.
    function automatic logic [HELPER_MAX_W-1:0] shift_in(
        input logic [HELPER_MAX_W-1:0] x,
        input int                      w,
        input logic                    b,
        input bit_order_e              ord
    );
        if (ord == ORDER_MSB)
            return (x << 1) | HELPER_MAX_W'(b);
        else
            return (x >> 1) | (HELPER_MAX_W'(b) << (w - 1));
    endfunction

endpackage

// File: rtl/spi_peri_if.sv
// rtl/spi_peri_if.sv - SPI peripheral serial lines and parallel word handshake (parity_err with SPI_PERI_PARITY_EN)
interface spi_peri_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_p_dat;
    logic              tx_ld;
    logic [DATA_W-1:0] rcvd_p_dat;
    logic              rcvd_valid;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;
`ifdef SPI_PERI_PARITY_EN
    logic              parity_err;
`endif

    modport slave (
        input  cs, mosi, tx_p_dat,
        output miso, tx_ld, rcvd_p_dat, rcvd_valid, word_cnt, busy
`ifdef SPI_PERI_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output cs, mosi, tx_p_dat,
        input  miso, tx_ld, rcvd_p_dat, rcvd_valid, word_cnt, busy
`ifdef SPI_PERI_PARITY_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/spi_peri_shifter.sv
// rtl/spi_peri_shifter.sv - parametrised shift register with clear, load-and-shift and bit-order select
module spi_peri_shifter
    import spi_peri_pkg::*;
#(
    parameter int         W     = 8,
    parameter bit_order_e ORDER = ORDER_MSB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    logic [W-1:0] src;

    // A load moves din one position immediately, so its lead bit is already on the line.
    assign src = load ? din : q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (load || shift)
            q <= W'(shift_in(HELPER_MAX_W'(src), W, sin, ORDER));
    end

endmodule

// File: rtl/spi_peri_rx_tx.sv
// rtl/spi_peri_rx_tx.sv - mode-0 SPI peripheral word receiver/transmitter; SPI_PERI_PARITY_EN adds a parity slot
module spi_peri_rx_tx
    import spi_peri_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic      sclk,
    input  logic      rst,
    spi_peri_if.slave bus
);
    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;
    localparam int         BCW   = cnt_width(DATA_W);
`ifdef SPI_PERI_PARITY_EN
    localparam int         LAST  = DATA_W;
`else
    localparam int         LAST  = DATA_W - 1;
`endif

    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, rx_word, rcvd_p_dat;
    logic [CNT_W-1:0]  word_cnt;
    logic              active, at_start, at_last, rx_en;
    logic              rcvd_valid, tx_ld, busy, miso;

    function automatic logic lead_bit(input logic [DATA_W-1:0] w);
        return (ORDER == ORDER_MSB) ? w[DATA_W-1] : w[0];
    endfunction

    assign active   = !bus.cs;
    assign at_start = (bit_cnt == '0);
    assign at_last  = (bit_cnt == BCW'(LAST));

`ifdef SPI_PERI_PARITY_EN
    logic tx_par, parity_err;
    // The data register holds still during the parity slot so it already has the whole word.
    assign rx_en          = active && (bit_cnt != BCW'(DATA_W));
    assign rx_word        = rx_shift;
    assign bus.parity_err = parity_err;
`else
    assign rx_en   = active;
    assign rx_word = DATA_W'(shift_in(HELPER_MAX_W'(rx_shift), DATA_W, bus.mosi, ORDER));
`endif

    spi_peri_shifter #(.W(DATA_W), .ORDER(ORDER)) u_rx (
        .clk   (sclk),
        .rst   (rst),
        .clr   (bus.cs),
        .load  (1'b0),
        .shift (rx_en),
        .sin   (bus.mosi),
        .din   ('0),
        .q     (rx_shift)
    );

    spi_peri_shifter #(.W(DATA_W), .ORDER(ORDER)) u_tx (
        .clk   (sclk),
        .rst   (rst),
        .clr   (bus.cs),
        .load  (active && at_start),
        .shift (active && !at_start),
        .sin   (1'b0),
        .din   (bus.tx_p_dat),
        .q     (tx_shift)
    );

    always_comb begin
        miso = 1'b0;
        if (active) begin
            if (at_start)
                miso = lead_bit(bus.tx_p_dat);
`ifdef SPI_PERI_PARITY_EN
            else if (bit_cnt == BCW'(DATA_W))
                miso = tx_par;
`endif
            else
                miso = lead_bit(tx_shift);
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            rcvd_p_dat <= '0;
            rcvd_valid <= 1'b0;
            tx_ld      <= 1'b0;
            word_cnt   <= '0;
            busy       <= 1'b0;
`ifdef SPI_PERI_PARITY_EN
            tx_par     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (bus.cs) begin
            bit_cnt    <= '0;
            rcvd_valid <= 1'b0;
            tx_ld      <= 1'b0;
            word_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            tx_ld      <= at_start;
            rcvd_valid <= at_last;
            bit_cnt    <= at_last ? '0 : bit_cnt + 1'b1;
            busy       <= !at_last;
`ifdef SPI_PERI_PARITY_EN
            if (at_start)
                tx_par <= even_parity(HELPER_MAX_W'(bus.tx_p_dat));
`endif
            if (at_last) begin
                rcvd_p_dat <= rx_word;
                if (word_cnt != '1)
                    word_cnt <= word_cnt + 1'b1;
`ifdef SPI_PERI_PARITY_EN
                parity_err <= (bus.mosi != even_parity(HELPER_MAX_W'(rx_word)));
`endif
            end
        end
    end

    assign bus.miso       = miso;
    assign bus.tx_ld      = tx_ld;
    assign bus.rcvd_p_dat = rcvd_p_dat;
    assign bus.rcvd_valid = rcvd_valid;
    assign bus.word_cnt   = word_cnt;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_spi_peri_rx_tx.sv
// tb/tb_spi_peri_rx_tx.sv - randomized and directed bench for spi_peri_rx_tx, MSB- and LSB-first instances, SPI_PERI_PARITY_EN aware
module tb_spi_peri_rx_tx;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
`ifdef SPI_PERI_PARITY_EN
    localparam int WLEN = DATA_W + 1;
`else
    localparam int WLEN = DATA_W;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    logic              cs_d   = 1'b1;
    logic              mosi_d = 1'b0;
    logic [DATA_W-1:0] tx_d   = '0;

    spi_peri_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bm ();
    spi_peri_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bl ();

    assign bm.cs = cs_d;  assign bm.mosi = mosi_d;  assign bm.tx_p_dat = tx_d;
    assign bl.cs = cs_d;  assign bl.mosi = mosi_d;  assign bl.tx_p_dat = tx_d;

    spi_peri_rx_tx #(.DATA_W(DATA_W), .MSB_FIRST(1), .CNT_W(CNT_W)) u_msb (
        .sclk (sclk), .rst (rst), .bus (bm.slave));
    spi_peri_rx_tx #(.DATA_W(DATA_W), .MSB_FIRST(0), .CNT_W(CNT_W)) u_lsb (
        .sclk (sclk), .rst (rst), .bus (bl.slave));

    // Reference model: bit position within the word and the bits seen on mosi in time order.
    int                n_cmp = 0;
    int                n_err = 0;
    int                pos   = 0;
    logic [WLEN-1:0]   bits  = '0;
    logic [DATA_W-1:0] tx_word = '0;
    logic [DATA_W-1:0] exp_rcvd_m = '0, exp_rcvd_l = '0;
    logic              exp_valid = 1'b0, exp_ld = 1'b0, exp_perr = 1'b0;
    logic [CNT_W-1:0]  exp_cnt = '0;
    logic [31:0]       cap = '0;
    logic [DATA_W-1:0] tx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit k of a word goes out k-th in the chosen order; the parity slot carries the xor of the word.
    function automatic logic exp_miso(input bit msb);
        logic [DATA_W-1:0] w;
        int idx;
        if (cs_d) return 1'b0;
        if (pos == DATA_W) return ^tx_word;
        w   = (pos == 0) ? tx_d : tx_word;
        idx = msb ? DATA_W - 1 - pos : pos;
        return w[idx];
    endfunction

    task automatic check_outs(input string tag);
        check({tag, "_valid_m"}, 32'(bm.rcvd_valid), 32'(exp_valid));
        check({tag, "_valid_l"}, 32'(bl.rcvd_valid), 32'(exp_valid));
        check({tag, "_ld"},      32'(bm.tx_ld),      32'(exp_ld));
        check({tag, "_rcvd_m"},  32'(bm.rcvd_p_dat), 32'(exp_rcvd_m));
        check({tag, "_rcvd_l"},  32'(bl.rcvd_p_dat), 32'(exp_rcvd_l));
        check({tag, "_cnt"},     32'(bm.word_cnt),   32'(exp_cnt));
        check({tag, "_busy"},    32'(bl.busy),       32'(pos != 0));
`ifdef SPI_PERI_PARITY_EN
        check({tag, "_perr"},    32'(bm.parity_err), 32'(exp_perr));
`endif
    endtask

    task automatic tick(input logic c, input logic m);
        logic [DATA_W-1:0] wm, wl;
        cs_d   = c;
        mosi_d = m;
        #1;
        check("miso_m", 32'(bm.miso), 32'(exp_miso(1'b1)));
        check("miso_l", 32'(bl.miso), 32'(exp_miso(1'b0)));
        cap = {cap[30:0], bm.miso};
        @(posedge sclk);
        exp_valid = 1'b0;
        exp_ld    = 1'b0;
        if (c) begin
            pos     = 0;
            exp_cnt = '0;
        end else begin
            if (pos == 0) begin
                tx_word = tx_d;
                exp_ld  = 1'b1;
            end
            bits[pos] = m;
            pos++;
            if (pos == WLEN) begin
                for (int i = 0; i < DATA_W; i++) begin
                    wm[DATA_W-1-i] = bits[i];
                    wl[i]          = bits[i];
                end
                exp_rcvd_m = wm;
                exp_rcvd_l = wl;
                exp_valid  = 1'b1;
                if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
`ifdef SPI_PERI_PARITY_EN
                exp_perr = (bits[DATA_W] != ^wm);
`endif
                pos = 0;
            end
        end
        @(negedge sclk);
        check_outs("tick");
        if (exp_ld) tx_d = (tx_q.size() != 0) ? tx_q.pop_front() : DATA_W'($urandom);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit bad_par);
        for (int i = DATA_W - 1; i >= 0; i--) tick(1'b0, w[i]);
`ifdef SPI_PERI_PARITY_EN
        tick(1'b0, (^w) ^ bad_par);
`else
        if (bad_par) $display("note: no parity slot in this build");
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        pos = 0; exp_valid = 1'b0; exp_ld = 1'b0; exp_perr = 1'b0;
        exp_cnt = '0; exp_rcvd_m = '0; exp_rcvd_l = '0;
        check_outs("rst");
        @(posedge sclk);
        @(negedge sclk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge sclk);
        pulse_reset();
        tick(1'b1, 1'b0);

        // 0xA5 in, 0x3C then 0x81 out back to back
        tx_d = 8'h3C;
        tx_q.push_back(8'h81);
        cap = '0;
        send_word(8'hA5, 1'b0);
        check("a5_rcvd", 32'(bm.rcvd_p_dat), 32'h0A5);
        check("a5_cnt",  32'(bm.word_cnt),   32'd1);
        send_word(8'h5A, 1'b0);
`ifdef SPI_PERI_PARITY_EN
        check("miso_stream", {16'h0, cap[17:10], cap[8:1]}, 32'h3C81);
`else
        check("miso_stream", {16'h0, cap[15:0]}, 32'h3C81);
`endif
        tick(1'b1, 1'b0);

        send_word(8'h80, 1'b0);
        check("lsb_rcvd", 32'(bl.rcvd_p_dat), 32'h01);
        tick(1'b1, 1'b0);

        send_word(8'h11, 1'b0); check("b2b_cnt1", 32'(bm.word_cnt), 32'd1);
        send_word(8'h22, 1'b0); check("b2b_cnt2", 32'(bm.word_cnt), 32'd2);
        send_word(8'h33, 1'b0); check("b2b_cnt3", 32'(bm.word_cnt), 32'd3);
        tick(1'b1, 1'b0);
        check("cs_cnt0", 32'(bm.word_cnt), 32'd0);

        for (int i = 0; i < 9; i++) send_word(DATA_W'($urandom), 1'b0);
        check("cnt_sat", 32'(bm.word_cnt), 32'(CNT_MAX));
        tick(1'b1, 1'b0);

        for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom));
        tick(1'b1, 1'b0);
        send_word(8'hF0, 1'b0);
        check("part_rcvd", 32'(bm.rcvd_p_dat), 32'hF0);

        for (int i = 0; i < 3; i++) tick(1'b0, 1'($urandom));
        pulse_reset();
        send_word(8'hC3, 1'b0);
        check("post_rst", 32'(bm.rcvd_p_dat), 32'hC3);
        tick(1'b1, 1'b0);

`ifdef SPI_PERI_PARITY_EN
        send_word(8'h07, 1'b0);
        check("par_ok",  32'(bm.parity_err), 32'd0);
        send_word(8'h07, 1'b1);
        check("par_bad", 32'(bm.parity_err), 32'd1);
        check("par_vld", 32'(bm.rcvd_valid), 32'd1);
        tick(1'b1, 1'b0);
`endif

        for (int i = 0; i < 600; i++) tick($urandom_range(0, 19) == 0, 1'($urandom));
        tick(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
